pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: issues ROM fetches and holds the word for decode.
// A ROM that stalls too long sets a sticky error flag, and fetching carries on.
module pc_fetch_unit #(
    parameter int unsigned           WIDTH      = 16,
    parameter logic [WIDTH-1:0]      RESET_ADDR = '0,
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_addr,
    output logic             rom_req,
    output logic [WIDTH-1:0] rom_addr,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pc,
    output logic             rom_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] TO_W = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_ADDR;
            instr_q <= '0;
            ipc_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
                if (jump_valid) pc_d = jump_addr;
            end
            S_ISSUE: begin
                if (jump_valid) begin
                    pc_d   = jump_addr;
                    wait_d = '0;
                end else if (rom_ack) begin
                    instr_d = rom_data;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + WIDTH'(1);
                    wait_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    // Flag is raised on the same edge the counter reaches TIMEOUT.
                    if (wait_q < TO_W) wait_d = wait_q + 8'd1;
                    if (wait_q >= TO_W - 8'd1) err_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (jump_valid) begin
                    pc_d    = jump_addr;
                    wait_d  = '0;
                    state_d = S_ISSUE;
                end else if (instr_ready) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_req     = (state_q == S_ISSUE);
    assign instr_valid = (state_q == S_HOLD);
    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign rom_err     = err_q;

endmodule
